// File: rtl/cache_miss_handler.sv
// Miss/write-through engine for the two-way data cache: services load misses and stores, drives the memory handshake and the cache fill port.
// Optional load-miss counter is enabled by defining MISS_COUNTER_EN; otherwise miss_count is tied to zero.
module cache_miss_handler #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SET_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cache_hit,
  output logic                  stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  fill_en,
  output logic                  fill_overwrite,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  error,
  output logic [31:0]           miss_count
);

  typedef enum logic [2:0] {
    IDLE,
    READ_REQ,
    WAIT_RSP,
    FILL,
    WRITE_REQ,
    ERROR
  } state_e;

  // A zero timeout still needs a legal one-bit timer; the compare is masked off instead.
  localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  hit_q;
  logic [TIMER_W-1:0]    timer_q;
  logic [TIMER_W-1:0]    timer_d;
  logic                  mem_req_valid_q;
  logic                  mem_we_q;
  logic                  fill_en_q;
  logic                  fill_overwrite_q;
  logic [DATA_WIDTH-1:0] fill_data_q;
  logic                  error_q;
  logic [ADDR_WIDTH-1:0] cpu_addr_word;
  logic                  timeout_now;
  logic [1:0]            unused_byte_offset;
  logic [SET_WIDTH-1:0]  unused_set_index;

  assign cpu_addr_word      = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
  assign timer_d            = timer_q + TIMER_W'(1);
  assign timeout_now        = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_MAX);
  assign unused_byte_offset = cpu_addr[1:0];
  assign unused_set_index   = addr_q[SET_WIDTH+1:2];

`ifdef MISS_COUNTER_EN
  logic [31:0] miss_count_q;
  logic [31:0] miss_count_d;
  assign miss_count_d = (miss_count_q == 32'hFFFF_FFFF) ? miss_count_q : miss_count_q + 32'd1;
  assign miss_count   = miss_count_q;
`else
  assign miss_count = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      wdata_q          <= '0;
      hit_q            <= 1'b0;
      timer_q          <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_we_q         <= 1'b0;
      fill_en_q        <= 1'b0;
      fill_overwrite_q <= 1'b0;
      fill_data_q      <= '0;
      error_q          <= 1'b0;
`ifdef MISS_COUNTER_EN
      miss_count_q     <= '0;
`endif
    end else begin
      fill_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req_valid && cpu_we) begin
            addr_q          <= cpu_addr_word;
            wdata_q         <= cpu_wdata;
            hit_q           <= cache_hit;
            mem_req_valid_q <= 1'b1;
            mem_we_q        <= 1'b1;
            state_q         <= WRITE_REQ;
          end else if (cpu_req_valid && !cache_hit) begin
            addr_q          <= cpu_addr_word;
            mem_req_valid_q <= 1'b1;
            mem_we_q        <= 1'b0;
            state_q         <= READ_REQ;
`ifdef MISS_COUNTER_EN
            miss_count_q    <= miss_count_d;
`endif
          end
        end
        READ_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            timer_q         <= '0;
            state_q         <= WAIT_RSP;
          end
        end
        // A response arriving in the timeout cycle still completes the refill.
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            fill_data_q      <= mem_rsp_data;
            fill_en_q        <= 1'b1;
            fill_overwrite_q <= 1'b0;
            state_q          <= FILL;
          end else if (timeout_now) begin
            error_q <= 1'b1;
            state_q <= ERROR;
          end else begin
            timer_q <= timer_d;
          end
        end
        FILL: begin
          fill_overwrite_q <= 1'b0;
          state_q          <= IDLE;
        end
        WRITE_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            if (hit_q) begin
              fill_data_q      <= wdata_q;
              fill_en_q        <= 1'b1;
              fill_overwrite_q <= 1'b1;
              state_q          <= FILL;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        ERROR: begin
          error_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the very cycle a miss or store is presented, so it is not registered.
  assign stall = (state_q != IDLE) || (cpu_req_valid && (cpu_we || !cache_hit));

  assign mem_req_valid  = mem_req_valid_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign fill_en        = fill_en_q;
  assign fill_overwrite = fill_overwrite_q;
  assign fill_addr      = addr_q;
  assign fill_data      = fill_data_q;
  assign error          = error_q;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Scoreboard bench for cache_miss_handler: CPU/memory driver pushes expected memory requests and fills; a negedge monitor pops and compares.
module tb_cache_miss_handler;

  localparam int TIMEOUT = 4;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        overwrite;
  } fill_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cache_hit;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        fill_en;
  logic        fill_overwrite;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        error;
  logic [31:0] miss_count;

  int    vectors = 0;
  int    miscompares = 0;
  int    missModel = 0;
  bit    monitorOn = 1'b0;
  req_t  expReq[$];
  fill_t expFill[$];
  req_t  curReq;
  fill_t curFill;

  cache_miss_handler #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .SET_WIDTH(3),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cache_hit(cache_hit),
    .stall(stall),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .fill_en(fill_en),
    .fill_overwrite(fill_overwrite),
    .fill_addr(fill_addr),
    .fill_data(fill_data),
    .error(error),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wordAlign(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] expectedMissCount();
`ifdef MISS_COUNTER_EN
    return 32'(missModel);
`else
    return 32'd0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junkCpu();
    cpu_req_valid = 1'($urandom);
    cpu_we        = 1'($urandom);
    cache_hit     = 1'($urandom);
    cpu_addr      = $urandom;
    cpu_wdata     = $urandom;
  endtask

  // One cycle in which the handler is known to be busy: CPU inputs are noise.
  task automatic busyCycle(input logic ready, input logic rspValid);
    tick();
    junkCpu();
    mem_req_ready = ready;
    mem_rsp_valid = rspValid;
    mem_rsp_data  = $urandom;
    @(negedge clk);
    checkOutput("stall while busy", 32'(stall), 32'd1);
  endtask

  task automatic idleCycle();
    tick();
    junkCpu();
    cpu_req_valid = 1'b0;
    mem_req_ready = 1'($urandom);
    mem_rsp_valid = 1'($urandom);
    mem_rsp_data  = $urandom;
    @(negedge clk);
    checkOutput("stall idle", 32'(stall), 32'd0);
  endtask

  task automatic loadHit(input logic [31:0] addr);
    tick();
    cpu_req_valid = 1'b1;
    cpu_we        = 1'b0;
    cache_hit     = 1'b1;
    cpu_addr      = addr;
    mem_req_ready = 1'($urandom);
    mem_rsp_valid = 1'($urandom);
    mem_rsp_data  = $urandom;
    @(negedge clk);
    checkOutput("stall load hit", 32'(stall), 32'd0);
  endtask

  task automatic loadMiss(input logic [31:0] addr, input int readyDelay, input int rspDelay,
                          input logic [31:0] data);
    tick();
    cpu_req_valid = 1'b1;
    cpu_we        = 1'b0;
    cache_hit     = 1'b0;
    cpu_addr      = addr;
    cpu_wdata     = $urandom;
    mem_req_ready = 1'($urandom);
    mem_rsp_valid = 1'($urandom);
    mem_rsp_data  = $urandom;
    expReq.push_back('{wordAlign(addr), 1'b0, 32'h0});
    missModel++;
    @(negedge clk);
    checkOutput("stall in miss cycle", 32'(stall), 32'd1);
    repeat (readyDelay) busyCycle(1'b0, 1'($urandom));
    busyCycle(1'b1, 1'($urandom));
    repeat (rspDelay) busyCycle(1'($urandom), 1'b0);
    tick();
    junkCpu();
    mem_req_ready = 1'($urandom);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    expFill.push_back('{wordAlign(addr), data, 1'b0});
    @(negedge clk);
    checkOutput("stall in rsp cycle", 32'(stall), 32'd1);
    busyCycle(1'($urandom), 1'($urandom));
    loadHit(addr);
  endtask

  task automatic storeOp(input logic [31:0] addr, input logic [31:0] data, input logic hit,
                         input int readyDelay);
    tick();
    cpu_req_valid = 1'b1;
    cpu_we        = 1'b1;
    cache_hit     = hit;
    cpu_addr      = addr;
    cpu_wdata     = data;
    mem_req_ready = 1'($urandom);
    mem_rsp_valid = 1'($urandom);
    mem_rsp_data  = $urandom;
    expReq.push_back('{wordAlign(addr), 1'b1, data});
    @(negedge clk);
    checkOutput("stall in store cycle", 32'(stall), 32'd1);
    repeat (readyDelay) busyCycle(1'b0, 1'($urandom));
    if (hit) expFill.push_back('{wordAlign(addr), data, 1'b1});
    busyCycle(1'b1, 1'($urandom));
    if (hit) busyCycle(1'($urandom), 1'($urandom));
    idleCycle();
  endtask

  task automatic doReset();
    tick();
    rst_n         = 1'b0;
    cpu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    expReq.delete();
    expFill.delete();
    missModel = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int kind);
    case (kind)
      0: idleCycle();
      1: loadHit($urandom);
      2: loadMiss($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT)), $urandom);
      default: storeOp($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
    endcase
  endtask

  // Monitor: every presented request must match the head of the request queue until accepted,
  // and every fill strobe consumes exactly one expected fill.
  always @(negedge clk) begin
    if (rst_n && monitorOn) begin
      if (fill_en) begin
        if (expFill.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected fill: got fill_en=1 addr 0x%08h, required no fill at %0t", fill_addr, $time);
        end else begin
          curFill = expFill.pop_front();
          checkOutput("fill_addr", fill_addr, curFill.addr);
          checkOutput("fill_data", fill_data, curFill.data);
          checkOutput("fill_overwrite", 32'(fill_overwrite), 32'(curFill.overwrite));
        end
      end
      if (mem_req_valid) begin
        if (expReq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected request: got mem_req_valid=1 addr 0x%08h, required idle bus at %0t", mem_addr, $time);
        end else begin
          curReq = expReq[0];
          checkOutput("mem_addr", mem_addr, curReq.addr);
          checkOutput("mem_we", 32'(mem_we), 32'(curReq.we));
          if (curReq.we) checkOutput("mem_wdata", mem_wdata, curReq.data);
          if (mem_req_ready) void'(expReq.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_we        = 1'b0;
    cpu_addr      = 32'h0;
    cpu_wdata     = 32'h0;
    cache_hit     = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    tick();
    tick();
    @(negedge clk);
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("reset fill_en", 32'(fill_en), 32'd0);
    checkOutput("reset error", 32'(error), 32'd0);
    checkOutput("reset miss_count", miss_count, 32'd0);
    tick();
    rst_n     = 1'b1;
    monitorOn = 1'b1;

    loadMiss(32'h0000_0104, 0, 1, 32'hDEAD_BEEF);
    loadHit(32'h0000_0104);
    storeOp(32'h0000_0020, 32'h1234_5678, 1'b1, 3);
    storeOp(32'h0000_0040, 32'hCAFE_F00D, 1'b0, 0);
    loadMiss(32'h0000_0203, 0, TIMEOUT, 32'hA5A5_0001);
    loadHit(32'h0000_0300);
    loadMiss(32'h0000_03C0, 2, 0, 32'h0BAD_CAFE);
    idleCycle();
    checkOutput("miss_count after directed", miss_count, expectedMissCount());

    // Memory never answers: the handler must give up after TIMEOUT+1 waiting cycles.
    tick();
    cpu_req_valid = 1'b1;
    cpu_we        = 1'b0;
    cache_hit     = 1'b0;
    cpu_addr      = 32'h0000_0500;
    mem_rsp_valid = 1'b0;
    expReq.push_back('{32'h0000_0500, 1'b0, 32'h0});
    missModel++;
    @(negedge clk);
    busyCycle(1'b1, 1'b0);
    for (int i = 0; i <= TIMEOUT; i++) begin
      busyCycle(1'($urandom), 1'b0);
      checkOutput("error before timeout", 32'(error), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      busyCycle(1'($urandom), 1'(i));
      checkOutput("error sticky", 32'(error), 32'd1);
    end
    doReset();
    cpu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = $urandom;
    @(negedge clk);
    checkOutput("error after reset", 32'(error), 32'd0);
    checkOutput("stall after reset", 32'(stall), 32'd0);
    checkOutput("miss_count after reset", miss_count, 32'd0);
    idleCycle();

    // Reset abandons a refill in flight; the late response must not fill.
    tick();
    cpu_req_valid = 1'b1;
    cpu_we        = 1'b0;
    cache_hit     = 1'b0;
    cpu_addr      = 32'h0000_0640;
    mem_rsp_valid = 1'b0;
    expReq.push_back('{32'h0000_0640, 1'b0, 32'h0});
    missModel++;
    @(negedge clk);
    busyCycle(1'b1, 1'b0);
    busyCycle(1'b0, 1'b0);
    doReset();
    cpu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h7777_7777;
    @(negedge clk);
    checkOutput("mem_req_valid after mid reset", 32'(mem_req_valid), 32'd0);
    checkOutput("fill_en after mid reset", 32'(fill_en), 32'd0);
    checkOutput("stall after mid reset", 32'(stall), 32'd0);
    idleCycle();

    for (int n = 0; n < 150; n++) applyStimulus(int'($urandom_range(0, 3)));
    idleCycle();
    idleCycle();
    checkOutput("miss_count final", miss_count, expectedMissCount());
    checkOutput("pending requests", 32'(expReq.size()), 32'd0);
    checkOutput("pending fills", 32'(expFill.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
